// File: rtl/dcache_ctrl_if.sv
// Bus bundle between the data-cache controller and its neighbours.
//   cpu_*  : single-request load/store channel from the LSQ side
//   cm_*   : control/data lines to and from the dcachemem array
//   mem_*  : block-granular memory port (writeback / fetch)
// Modports: slave = controller view, master = environment view (LSQ, array, memory).
interface dcache_ctrl_if #(
   parameter int unsigned TAG_W    = 8,
   parameter int unsigned INDEX_W  = 3,
   parameter int unsigned OFFSET_W = 3,
   parameter int unsigned BLOCK_W  = 64
);
   localparam int unsigned ADDR_W = TAG_W + INDEX_W + OFFSET_W;

   // LSQ side
   logic                 cpu_req_valid;
   logic                 cpu_req_ready;
   logic                 cpu_req_write;
   logic [ADDR_W-1:0]    cpu_req_addr;
   logic [BLOCK_W-1:0]   cpu_req_wdata;
   logic                 cpu_resp_valid;
   logic [BLOCK_W-1:0]   cpu_resp_rdata;

   // array side
   logic                 cm_read_enable;
   logic                 cm_write_enable;
   logic                 cm_fill_en;
   logic                 cm_fill_dirty;
   logic [TAG_W-1:0]     cm_tag;
   logic [INDEX_W-1:0]   cm_index;
   logic [BLOCK_W-1:0]   cm_data_in;
   logic [BLOCK_W-1:0]   cm_data_out;
   logic                 cm_miss;
   logic                 cm_dirty;
   logic [TAG_W-1:0]     cm_dirty_tag;
   logic [INDEX_W-1:0]   cm_dirty_index;

   // memory side
   logic                 mem_req_valid;
   logic                 mem_req_ready;
   logic                 mem_req_write;
   logic [ADDR_W-1:0]    mem_req_addr;
   logic [BLOCK_W-1:0]   mem_req_wdata;
   logic                 mem_rvalid;
   logic [BLOCK_W-1:0]   mem_rdata;

   modport slave (
      input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
      output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
      output cm_read_enable, cm_write_enable, cm_fill_en, cm_fill_dirty,
      output cm_tag, cm_index, cm_data_in,
      input  cm_data_out, cm_miss, cm_dirty, cm_dirty_tag, cm_dirty_index,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
      input  mem_req_ready, mem_rvalid, mem_rdata
   );

   modport master (
      output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
      input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
      input  cm_read_enable, cm_write_enable, cm_fill_en, cm_fill_dirty,
      input  cm_tag, cm_index, cm_data_in,
      output cm_data_out, cm_miss, cm_dirty, cm_dirty_tag, cm_dirty_index,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
      output mem_req_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Data-cache sequencing controller. Accepts one block-granular load/store at a
// time, looks it up in the dcachemem array, writes back a dirty victim, fetches
// the missing block (loads only; stores are full-block and allocate directly),
// fills the array and returns a one-cycle response.
// Ports:
//   clock : system clock
//   reset : synchronous active-low reset
//   bus   : dcache_ctrl_if.slave bundle (cpu_*, cm_*, mem_* signals)
// All outputs are decoded from the state register and capture registers only,
// so no input reaches an output combinationally.
module dcache_ctrl #(
   parameter int unsigned TAG_W    = 8,
   parameter int unsigned INDEX_W  = 3,
   parameter int unsigned OFFSET_W = 3,
   parameter int unsigned BLOCK_W  = 64
) (
   input  logic         clock,
   input  logic         reset,
   dcache_ctrl_if.slave bus
);
   localparam int unsigned ADDR_W = TAG_W + INDEX_W + OFFSET_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WB_REQ,
      S_FILL_REQ,
      S_FILL_WAIT,
      S_REFILL,
      S_RESP
   } state_t;

   state_t state, state_nxt;

   // request capture
   logic               req_write_q;
   logic [ADDR_W-1:0]  req_addr_q;
   logic [BLOCK_W-1:0] req_wdata_q;

   // victim record and load data (hit data or fetched block)
   logic [TAG_W-1:0]   vic_tag_q;
   logic [INDEX_W-1:0] vic_index_q;
   logic [BLOCK_W-1:0] vic_data_q;
   logic [BLOCK_W-1:0] rdata_q;

   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_index;

   // offset bits are dropped; the array works on whole blocks
   assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
   assign req_index = req_addr_q[OFFSET_W +: INDEX_W];

   // state register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and state-decoded outputs
   always_comb begin
      state_nxt           = state;
      bus.cpu_req_ready   = 1'b0;
      bus.cpu_resp_valid  = 1'b0;
      bus.cpu_resp_rdata  = '0;
      bus.cm_read_enable  = 1'b0;
      bus.cm_write_enable = 1'b0;
      bus.cm_fill_en      = 1'b0;
      bus.cm_fill_dirty   = 1'b0;
      bus.cm_tag          = '0;
      bus.cm_index        = '0;
      bus.cm_data_in      = '0;
      bus.mem_req_valid   = 1'b0;
      bus.mem_req_write   = 1'b0;
      bus.mem_req_addr    = '0;
      bus.mem_req_wdata   = '0;

      unique case (state)
         S_IDLE: begin
            bus.cpu_req_ready = 1'b1;
            if (bus.cpu_req_valid) begin
               state_nxt = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            // store hits are written by the array on the same edge the miss is sampled
            bus.cm_tag          = req_tag;
            bus.cm_index        = req_index;
            bus.cm_read_enable  = !req_write_q;
            bus.cm_write_enable = req_write_q;
            bus.cm_data_in      = req_wdata_q;
            if (!bus.cm_miss) begin
               state_nxt = S_RESP;
            end else if (bus.cm_dirty) begin
               state_nxt = S_WB_REQ;
            end else if (req_write_q) begin
               state_nxt = S_REFILL;
            end else begin
               state_nxt = S_FILL_REQ;
            end
         end

         S_WB_REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_write = 1'b1;
            bus.mem_req_addr  = {vic_tag_q, vic_index_q, {OFFSET_W{1'b0}}};
            bus.mem_req_wdata = vic_data_q;
            if (bus.mem_req_ready) begin
               state_nxt = req_write_q ? S_REFILL : S_FILL_REQ;
            end
         end

         S_FILL_REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = {req_tag, req_index, {OFFSET_W{1'b0}}};
            if (bus.mem_req_ready) begin
               state_nxt = S_FILL_WAIT;
            end
         end

         S_FILL_WAIT: begin
            if (bus.mem_rvalid) begin
               state_nxt = S_REFILL;
            end
         end

         S_REFILL: begin
            // stores overwrite the whole block, so they allocate dirty without a fetch
            bus.cm_fill_en    = 1'b1;
            bus.cm_fill_dirty = req_write_q;
            bus.cm_tag        = req_tag;
            bus.cm_index      = req_index;
            bus.cm_data_in    = req_write_q ? req_wdata_q : rdata_q;
            state_nxt         = S_RESP;
         end

         S_RESP: begin
            bus.cpu_resp_valid = 1'b1;
            bus.cpu_resp_rdata = req_write_q ? '0 : rdata_q;
            state_nxt          = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // request capture, victim record and load-data latch
   always_ff @(posedge clock) begin
      if (!reset) begin
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         vic_tag_q   <= '0;
         vic_index_q <= '0;
         vic_data_q  <= '0;
         rdata_q     <= '0;
      end else begin
         if (state == S_IDLE && bus.cpu_req_valid) begin
            req_write_q <= bus.cpu_req_write;
            req_addr_q  <= bus.cpu_req_addr;
            req_wdata_q <= bus.cpu_req_wdata;
         end
         if (state == S_LOOKUP) begin
            if (!bus.cm_miss) begin
               rdata_q <= bus.cm_data_out;
            end else begin
               vic_tag_q   <= bus.cm_dirty_tag;
               vic_index_q <= bus.cm_dirty_index;
               vic_data_q  <= bus.cm_data_out;
            end
         end
         // rvalid outside FILL_WAIT is deliberately ignored
         if (state == S_FILL_WAIT && bus.mem_rvalid) begin
            rdata_q <= bus.mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl: reset state, load hit, clean load miss,
// dirty store miss with a stalled writeback, and reset during FILL_WAIT.
module tb_dcache_ctrl;
   logic clock;
   logic reset;

   dcache_ctrl_if bus ();

   dcache_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // handshake / event monitors
   int n_wb   = 0;
   int n_rd   = 0;
   int n_fill = 0;
   int n_resp = 0;

   always @(posedge clock) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
         if (bus.mem_req_write) n_wb++;
         else                   n_rd++;
      end
      if (bus.cm_fill_en)     n_fill++;
      if (bus.cpu_resp_valid) n_resp++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic wr, input logic [13:0] addr, input logic [63:0] wdata);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_write = wr;
      bus.cpu_req_addr  = addr;
      bus.cpu_req_wdata = wdata;
   endtask

   task automatic idle_req();
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_write = 1'b0;
      bus.cpu_req_addr  = '0;
      bus.cpu_req_wdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wb0, rd0, fill0, resp0;
      logic [13:0] a;

      reset = 1'b0;
      idle_req();
      bus.cm_data_out    = '0;
      bus.cm_miss        = 1'b0;
      bus.cm_dirty       = 1'b0;
      bus.cm_dirty_tag   = '0;
      bus.cm_dirty_index = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_rvalid     = 1'b0;
      bus.mem_rdata      = '0;

      // reset held two cycles
      tick();
      tick();
      reset = 1'b1;
      check("rst_ready",   64'(bus.cpu_req_ready),   64'd1);
      check("rst_resp",    64'(bus.cpu_resp_valid),  64'd0);
      check("rst_rd_en",   64'(bus.cm_read_enable),  64'd0);
      check("rst_wr_en",   64'(bus.cm_write_enable), 64'd0);
      check("rst_fill",    64'(bus.cm_fill_en),      64'd0);
      check("rst_tag",     64'(bus.cm_tag),          64'd0);
      check("rst_memv",    64'(bus.mem_req_valid),   64'd0);
      check("rst_memaddr", 64'(bus.mem_req_addr),    64'd0);

      // load hit: tag 0x12 index 3, nonzero offset ignored
      wb0 = n_wb; rd0 = n_rd;
      bus.cm_miss     = 1'b0;
      bus.cm_data_out = 64'hDEADBEEF_00000001;
      a = {8'h12, 3'd3, 3'd5};
      send(1'b0, a, 64'h0);
      tick();                                        // cycle 1: LOOKUP
      idle_req();
      check("hit_rd_en",  64'(bus.cm_read_enable),  64'd1);
      check("hit_wr_en",  64'(bus.cm_write_enable), 64'd0);
      check("hit_tag",    64'(bus.cm_tag),          64'h12);
      check("hit_index",  64'(bus.cm_index),        64'd3);
      check("hit_ready",  64'(bus.cpu_req_ready),   64'd0);
      tick();                                        // cycle 2: RESP
      check("hit_resp",   64'(bus.cpu_resp_valid),  64'd1);
      check("hit_rdata",  bus.cpu_resp_rdata,       64'hDEADBEEF_00000001);
      check("hit_memv",   64'(bus.mem_req_valid),   64'd0);
      tick();
      check("hit_idle",   64'(bus.cpu_req_ready),   64'd1);
      check("hit_resp0",  64'(bus.cpu_resp_valid),  64'd0);
      check("hit_nomem",  64'(n_wb + n_rd - wb0 - rd0), 64'd0);

      // clean load miss, memory ready immediately, data 4 cycles after acceptance
      wb0 = n_wb; rd0 = n_rd; fill0 = n_fill;
      bus.cm_miss       = 1'b1;
      bus.cm_dirty      = 1'b0;
      bus.cm_data_out   = 64'h0BAD_0BAD_0BAD_0BAD;
      bus.mem_req_ready = 1'b1;
      a = {8'h34, 3'd5, 3'd7};
      send(1'b0, a, 64'h0);
      tick();                                        // cycle 1: LOOKUP
      idle_req();
      check("cm_rd_en",   64'(bus.cm_read_enable),  64'd1);
      tick();                                        // cycle 2: FILL_REQ
      bus.cm_miss = 1'b0;
      a = {8'h34, 3'd5, 3'd0};
      check("cm_memv",    64'(bus.mem_req_valid),   64'd1);
      check("cm_memw",    64'(bus.mem_req_write),   64'd0);
      check("cm_memaddr", 64'(bus.mem_req_addr),    64'(a));
      tick();                                        // cycle 3: FILL_WAIT
      bus.mem_req_ready = 1'b0;
      check("cm_memv0",   64'(bus.mem_req_valid),   64'd0);
      tick();
      tick();
      tick();                                        // cycle 6
      check("cm_nofill",  64'(n_fill - fill0),      64'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'hA5A5A5A5_A5A5A5A5;
      tick();                                        // cycle 7: REFILL
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      check("cm_fill",    64'(bus.cm_fill_en),      64'd1);
      check("cm_fdirty",  64'(bus.cm_fill_dirty),   64'd0);
      check("cm_fdata",   bus.cm_data_in,           64'hA5A5A5A5_A5A5A5A5);
      check("cm_ftag",    64'(bus.cm_tag),          64'h34);
      check("cm_findex",  64'(bus.cm_index),        64'd5);
      check("cm_frd_en",  64'(bus.cm_read_enable),  64'd0);
      tick();                                        // cycle 8: RESP
      check("cm_resp",    64'(bus.cpu_resp_valid),  64'd1);
      check("cm_rdata",   bus.cpu_resp_rdata,       64'hA5A5A5A5_A5A5A5A5);
      check("cm_nfetch",  64'(n_rd - rd0),          64'd1);
      check("cm_nwb",     64'(n_wb - wb0),          64'd0);
      tick();

      // dirty store miss, writeback stalled 5 cycles
      wb0 = n_wb; rd0 = n_rd; fill0 = n_fill;
      bus.cm_miss        = 1'b1;
      bus.cm_dirty       = 1'b1;
      bus.cm_dirty_tag   = 8'h07;
      bus.cm_dirty_index = 3'd2;
      bus.cm_data_out    = 64'h11111111_11111111;
      a = {8'h55, 3'd2, 3'd0};
      send(1'b1, a, 64'h22222222_22222222);
      tick();                                        // cycle 1: LOOKUP
      idle_req();
      check("dm_wr_en",   64'(bus.cm_write_enable), 64'd1);
      check("dm_rd_en",   64'(bus.cm_read_enable),  64'd0);
      check("dm_din",     bus.cm_data_in,           64'h22222222_22222222);
      tick();                                        // cycle 2: WB_REQ
      bus.cm_miss     = 1'b0;
      bus.cm_dirty    = 1'b0;
      bus.cm_data_out = '0;
      a = {8'h07, 3'd2, 3'd0};
      for (int i = 0; i < 5; i++) begin
         check("wb_memv",  64'(bus.mem_req_valid),  64'd1);
         check("wb_memw",  64'(bus.mem_req_write),  64'd1);
         check("wb_addr",  64'(bus.mem_req_addr),   64'(a));
         check("wb_wdata", bus.mem_req_wdata,       64'h11111111_11111111);
         if (i == 4) bus.mem_req_ready = 1'b1;
         tick();
      end                                            // now cycle 7: REFILL
      bus.mem_req_ready = 1'b0;
      check("dm_fill",    64'(bus.cm_fill_en),      64'd1);
      check("dm_fdirty",  64'(bus.cm_fill_dirty),   64'd1);
      check("dm_fdata",   bus.cm_data_in,           64'h22222222_22222222);
      check("dm_ftag",    64'(bus.cm_tag),          64'h55);
      check("dm_findex",  64'(bus.cm_index),        64'd2);
      check("dm_memv0",   64'(bus.mem_req_valid),   64'd0);
      tick();                                        // cycle 8: RESP
      check("dm_resp",    64'(bus.cpu_resp_valid),  64'd1);
      check("dm_rdata",   bus.cpu_resp_rdata,       64'd0);
      check("dm_nwb",     64'(n_wb - wb0),          64'd1);
      check("dm_nfetch",  64'(n_rd - rd0),          64'd0);
      check("dm_nfill",   64'(n_fill - fill0),      64'd1);
      tick();

      // reset during FILL_WAIT, late rvalid must be ignored
      fill0 = n_fill; resp0 = n_resp;
      bus.cm_miss       = 1'b1;
      bus.cm_dirty      = 1'b0;
      bus.mem_req_ready = 1'b1;
      a = {8'h40, 3'd6, 3'd0};
      send(1'b0, a, 64'h0);
      tick();                                        // LOOKUP
      idle_req();
      tick();                                        // FILL_REQ
      bus.cm_miss = 1'b0;
      tick();                                        // FILL_WAIT
      bus.mem_req_ready = 1'b0;
      check("rw_memv0",   64'(bus.mem_req_valid),   64'd0);
      reset = 1'b0;
      tick();                                        // reset sampled -> IDLE
      reset = 1'b1;
      check("rw_ready",   64'(bus.cpu_req_ready),   64'd1);
      tick();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'hBADBADBA_DBADBADB;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      check("rw_ready2",  64'(bus.cpu_req_ready),   64'd1);
      check("rw_fill0",   64'(bus.cm_fill_en),      64'd0);
      tick();
      check("rw_nfill",   64'(n_fill - fill0),      64'd0);
      check("rw_nresp",   64'(n_resp - resp0),      64'd0);

      // next request served normally (hit)
      bus.cm_miss     = 1'b0;
      bus.cm_data_out = 64'h01234567_89ABCDEF;
      a = {8'h12, 3'd3, 3'd0};
      send(1'b0, a, 64'h0);
      tick();
      idle_req();
      check("rn_rd_en",   64'(bus.cm_read_enable),  64'd1);
      tick();
      check("rn_resp",    64'(bus.cpu_resp_valid),  64'd1);
      check("rn_rdata",   bus.cpu_resp_rdata,       64'h01234567_89ABCDEF);
      tick();
      check("rn_idle",    64'(bus.cpu_req_ready),   64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
